axi_lite_write_arbiter: RTL and testbench

- Shares one AXI4-Lite master write channel between NUM_PORTS AXI-Stream command requesters.
- Each command word is {address, data}.
- The block sits upstream of memory-mapped write slaves such as the stream writer cores, so several hardware sequencers can configure the same register space.
- Round-robin arbitration; one outstanding transaction; write response checked and errors counted.

---
 rtl/axi_lite_write_arbiter_pkg.sv | 27 ++
 rtl/axi_lite_write_arbiter_rr_arbiter.sv | 33 +++
 rtl/axi_lite_write_arbiter.sv | 139 +++++++++++++
 tb/tb_axi_lite_write_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_write_arbiter_pkg.sv
// Shared definitions for the AXI4-Lite write arbiter: FSM encoding,
// response codes and a width helper.
package axi_lite_write_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_W = 16;

  // Bits needed to encode n distinct indices (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/axi_lite_write_arbiter_rr_arbiter.sv
// Combinational round-robin select: the first request strictly after the
// last grant wins, wrapping around the request vector.
module axi_lite_write_arbiter_rr_arbiter
  import axi_lite_write_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [N-1:0]     gnt_oh_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o
);

  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_oh_o    = '0;
    gnt_idx_o   = last_i;
    gnt_valid_o = 1'b0;
    idx         = '0;
    for (int off = 1; off <= N; off++) begin
      idx = IDX_W'((int'(last_i) + off) % N);
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_valid_o   = 1'b1;
        gnt_oh_o[idx] = 1'b1;
        gnt_idx_o     = idx;
      end
    end
  end

endmodule

// File: rtl/axi_lite_write_arbiter.sv
// Shares one AXI4-Lite write channel between NUM_PORTS stream command
// requesters, one transaction at a time, counting non-OKAY responses.
module axi_lite_write_arbiter
  import axi_lite_write_arbiter_pkg::*;
#(
  parameter int NUM_PORTS      = 2,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 16
) (
  input  logic                                                 aclk,
  input  logic                                                 areset,
  input  logic [NUM_PORTS*(AXI_ADDR_WIDTH+AXI_DATA_WIDTH)-1:0] s_axis_tdata,
  input  logic [NUM_PORTS-1:0]                                 s_axis_tvalid,
  output logic [NUM_PORTS-1:0]                                 s_axis_tready,
  output logic [AXI_ADDR_WIDTH-1:0]                            m_axi_awaddr,
  output logic                                                 m_axi_awvalid,
  input  logic                                                 m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]                            m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0]                          m_axi_wstrb,
  output logic                                                 m_axi_wvalid,
  input  logic                                                 m_axi_wready,
  input  logic [1:0]                                           m_axi_bresp,
  input  logic                                                 m_axi_bvalid,
  output logic                                                 m_axi_bready,
  output logic [clog2(NUM_PORTS)-1:0]                          grant,
  output logic                                                 busy,
  output logic [15:0]                                          err_count
);

  // Handshakes: a transfer happens on any rising edge where valid and ready
  // are both high; valid and payload never change while valid is waiting.

  localparam int CMD_W = AXI_ADDR_WIDTH + AXI_DATA_WIDTH;
  localparam int IDX_W = clog2(NUM_PORTS);

  state_e                    state_q, state_d;
  logic [IDX_W-1:0]          grant_q, grant_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [AXI_DATA_WIDTH-1:0] data_q, data_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [ERR_W-1:0]          err_cnt_q, err_cnt_d;

  logic [NUM_PORTS-1:0]      arb_oh;
  logic [IDX_W-1:0]          arb_idx;
  logic                      arb_valid;
  logic [CMD_W-1:0]          sel_cmd;

  axi_lite_write_arbiter_rr_arbiter #(
    .N     (NUM_PORTS),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i       (s_axis_tvalid),
    .last_i      (grant_q),
    .gnt_oh_o    (arb_oh),
    .gnt_idx_o   (arb_idx),
    .gnt_valid_o (arb_valid)
  );

  always_comb begin
    sel_cmd = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (arb_oh[i]) sel_cmd = s_axis_tdata[i*CMD_W +: CMD_W];
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_IDLE;
      grant_q   <= IDX_W'(NUM_PORTS - 1);
      addr_q    <= '0;
      data_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    data_d        = data_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    err_cnt_d     = err_cnt_q;
    s_axis_tready = '0;
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    busy          = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        // Accept in the same cycle the request is seen: tready is a pulse.
        if (arb_valid) begin
          s_axis_tready    = arb_oh;
          grant_d          = arb_idx;
          {addr_d, data_d} = sel_cmd;
          aw_done_d        = 1'b0;
          w_done_d         = 1'b0;
          state_d          = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        m_axi_awvalid = !aw_done_q;
        m_axi_wvalid  = !w_done_q;
        if (m_axi_awvalid && m_axi_awready) aw_done_d = 1'b1;
        if (m_axi_wvalid && m_axi_wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          if (m_axi_bresp != RESP_OKAY && err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
          end
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign m_axi_awaddr = addr_q;
  assign m_axi_wdata  = data_q;
  assign m_axi_wstrb  = '1;
  assign grant        = grant_q;
  assign err_count    = err_cnt_q;

endmodule

// File: tb/tb_axi_lite_write_arbiter.sv
// Bench for axi_lite_write_arbiter: directed scenarios with literal
// expectations plus a random phase against a transaction-level model.
module tb_axi_lite_write_arbiter;

  localparam int NP = 4;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int CW = AW + DW;

  logic              aclk = 1'b0;
  logic              areset = 1'b1;
  logic [NP*CW-1:0]  s_axis_tdata = '0;
  logic [NP-1:0]     s_axis_tvalid = '0;
  logic [NP-1:0]     s_axis_tready;
  logic [AW-1:0]     m_axi_awaddr;
  logic              m_axi_awvalid;
  logic              m_axi_awready = 1'b0;
  logic [DW-1:0]     m_axi_wdata;
  logic [DW/8-1:0]   m_axi_wstrb;
  logic              m_axi_wvalid;
  logic              m_axi_wready = 1'b0;
  logic [1:0]        m_axi_bresp = 2'b00;
  logic              m_axi_bvalid = 1'b0;
  logic              m_axi_bready;
  logic [1:0]        grant;
  logic              busy;
  logic [15:0]       err_count;

  axi_lite_write_arbiter #(
    .NUM_PORTS      (NP),
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW)
  ) dut (
    .aclk          (aclk),
    .areset        (areset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axi_awaddr  (m_axi_awaddr),
    .m_axi_awvalid (m_axi_awvalid),
    .m_axi_awready (m_axi_awready),
    .m_axi_wdata   (m_axi_wdata),
    .m_axi_wstrb   (m_axi_wstrb),
    .m_axi_wvalid  (m_axi_wvalid),
    .m_axi_wready  (m_axi_wready),
    .m_axi_bresp   (m_axi_bresp),
    .m_axi_bvalid  (m_axi_bvalid),
    .m_axi_bready  (m_axi_bready),
    .grant         (grant),
    .busy          (busy),
    .err_count     (err_count)
  );

  // ---------------- clock ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- slave configuration ----------------
  int         aw_lat_cfg = 0;
  int         w_lat_cfg  = 0;
  int         b_lat_cfg  = 0;
  logic [1:0] resp_cfg   = 2'b00;
  bit         slv_rand   = 1'b0;
  logic       preload_req = 1'b0;

  // ---------------- AXI slave driver ----------------
  always begin : slave_drv
    int aw_wait, w_wait, b_wait;
    int r_aw, r_w, r_b;
    bit got_aw, got_w;
    @(negedge aclk);
    if (areset) begin
      aw_wait = 0; w_wait = 0; b_wait = 0; got_aw = 0; got_w = 0;
    end else begin
      if (m_axi_bvalid && m_axi_bready) begin
        got_aw = 0; got_w = 0; b_wait = 0;
        r_b = $urandom_range(0, 3);
      end else if (got_aw && got_w) begin
        b_wait++;
      end
      if (m_axi_awvalid) begin
        if (m_axi_awready) begin got_aw = 1; aw_wait = 0; r_aw = $urandom_range(0, 3); end
        else aw_wait++;
      end
      if (m_axi_wvalid) begin
        if (m_axi_wready) begin got_w = 1; w_wait = 0; r_w = $urandom_range(0, 3); end
        else w_wait++;
      end
    end
    @(posedge aclk); #1;
    m_axi_awready = (aw_wait >= (slv_rand ? r_aw : aw_lat_cfg));
    m_axi_wready  = (w_wait  >= (slv_rand ? r_w  : w_lat_cfg));
    if (!m_axi_bvalid) begin
      if (slv_rand) begin
        case ($urandom_range(0, 3))
          0, 1:    m_axi_bresp = 2'b00;
          2:       m_axi_bresp = 2'b10;
          default: m_axi_bresp = 2'b11;
        endcase
      end else begin
        m_axi_bresp = resp_cfg;
      end
    end
    m_axi_bvalid = got_aw && got_w && (b_wait >= (slv_rand ? r_b : b_lat_cfg));
  end

  // ---------------- behavioural model and per-cycle compare ----------------
  logic [AW-1:0] exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];

  always begin : cmp
    bit          m_busy, m_aw_pend, m_w_pend, found;
    int          m_last, sel;
    logic [15:0] m_err;
    logic [NP-1:0] exp_rdy;
    logic        exp_bready;
    @(negedge aclk);
    if (areset) begin
      m_busy = 0; m_aw_pend = 0; m_w_pend = 0; m_last = NP - 1; m_err = 16'h0;
      exp_aw_q.delete(); exp_w_q.delete();
      check("rst_tready", s_axis_tready, 0);
      check("rst_awvalid", m_axi_awvalid, 0);
      check("rst_wvalid", m_axi_wvalid, 0);
      check("rst_bready", m_axi_bready, 0);
      check("rst_busy", busy, 0);
      check("rst_grant", grant, NP - 1);
      check("rst_err", err_count, 0);
    end else begin
      if (preload_req) m_err = 16'hFFFC;
      // Expected acceptance: first valid port after the last grant, only when idle.
      exp_rdy = '0;
      sel = 0;
      found = 0;
      if (!m_busy) begin
        for (int off = 1; off <= NP; off++) begin
          if (!found && s_axis_tvalid[(m_last + off) % NP]) begin
            sel = (m_last + off) % NP;
            exp_rdy[sel] = 1'b1;
            found = 1;
          end
        end
      end
      exp_bready = m_busy && !m_aw_pend && !m_w_pend;
      check("tready", s_axis_tready, exp_rdy);
      check("tready_onehot", ($countones(s_axis_tready) <= 1), 1);
      check("grant", grant, m_last);
      check("busy", busy, m_busy);
      check("err_count", err_count, m_err);
      check("awvalid", m_axi_awvalid, m_busy && m_aw_pend);
      check("wvalid", m_axi_wvalid, m_busy && m_w_pend);
      check("bready", m_axi_bready, exp_bready);
      check("wstrb", m_axi_wstrb, 4'hF);
      if (m_aw_pend && exp_aw_q.size() > 0) check("awaddr", m_axi_awaddr, exp_aw_q[0]);
      if (m_w_pend && exp_w_q.size() > 0)   check("wdata", m_axi_wdata, exp_w_q[0]);
      // Advance the model across the coming rising edge.
      if (found) begin
        exp_aw_q.push_back(s_axis_tdata[sel*CW + DW +: AW]);
        exp_w_q.push_back(s_axis_tdata[sel*CW +: DW]);
        m_last = sel; m_busy = 1; m_aw_pend = 1; m_w_pend = 1;
      end else if (m_busy) begin
        if (m_aw_pend && m_axi_awready) begin m_aw_pend = 0; void'(exp_aw_q.pop_front()); end
        if (m_w_pend && m_axi_wready)   begin m_w_pend = 0;  void'(exp_w_q.pop_front()); end
        if (exp_bready && m_axi_bvalid) begin
          if (m_axi_bresp != 2'b00 && m_err != 16'hFFFF) m_err = m_err + 16'h1;
          m_busy = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic reset_dut();
    @(posedge aclk); #1;
    areset = 1'b1;
    s_axis_tvalid = '0;
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    areset = 1'b0;
  endtask

  task automatic send(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [NP-1:0] rdy);
    int n;
    @(posedge aclk); #1;
    s_axis_tvalid[p] = 1'b1;
    s_axis_tdata[p*CW +: CW] = {a, d};
    n = 0;
    rdy = '0;
    forever begin
      @(negedge aclk);
      if (s_axis_tready[p]) begin rdy = s_axis_tready; break; end
      n++;
      if (n > 50) begin check("send_timeout", 0, 1); break; end
    end
    @(posedge aclk); #1;
    s_axis_tvalid[p] = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge aclk);
    while (busy && n < 100) begin @(negedge aclk); n++; end
    check("idle_timeout", busy, 0);
  endtask

  // ---------------- directed and random stimulus ----------------
  initial begin : stim
    logic [NP-1:0] rdy, hs;
    int order[8];
    int exp_order[8];
    int n, cyc;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    reset_dut();
    @(negedge aclk);
    check("init_grant", grant, 2'd3);
    check("init_busy", busy, 0);
    check("init_err", err_count, 0);

    // Single request, all channels ready immediately.
    send(1, 16'h0010, 32'hDEADBEEF, rdy);
    check("single_tready", rdy, 4'b0010);
    @(negedge aclk);
    check("single_awvalid", m_axi_awvalid, 1);
    check("single_wvalid", m_axi_wvalid, 1);
    check("single_awaddr", m_axi_awaddr, 16'h0010);
    check("single_wdata", m_axi_wdata, 32'hDEADBEEF);
    @(negedge aclk);
    check("single_bready", m_axi_bready, 1);
    check("single_busy_resp", busy, 1);
    @(negedge aclk);
    check("single_busy_done", busy, 0);
    check("single_grant", grant, 2'd1);

    // Fairness with every port requesting continuously.
    reset_dut();
    @(posedge aclk); #1;
    for (int p = 0; p < NP; p++) begin
      s_axis_tvalid[p] = 1'b1;
      s_axis_tdata[p*CW +: CW] = {16'(p * 16), 32'(p + 100)};
    end
    n = 0; cyc = 0;
    while (n < 8 && cyc < 100) begin
      @(negedge aclk);
      cyc++;
      if (s_axis_tready != '0) begin
        for (int p = 0; p < NP; p++) if (s_axis_tready[p]) order[n] = p;
        n++;
      end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = '0;
    check("fair_count", n, 8);
    for (int i = 0; i < 8; i++) check("fair_order", order[i], exp_order[i]);
    wait_idle();

    // Skewed handshakes: address channel stalls three cycles.
    aw_lat_cfg = 3;
    send(0, 16'h0ABC, 32'h12345678, rdy);
    @(negedge aclk);
    check("skew_aw1", m_axi_awvalid, 1);
    check("skew_w1", m_axi_wvalid, 1);
    for (int k = 2; k <= 4; k++) begin
      @(negedge aclk);
      check("skew_aw_hold", m_axi_awvalid, 1);
      check("skew_aw_addr", m_axi_awaddr, 16'h0ABC);
      check("skew_w_drop", m_axi_wvalid, 0);
      check("skew_no_bready", m_axi_bready, 0);
    end
    @(negedge aclk);
    check("skew_aw_done", m_axi_awvalid, 0);
    check("skew_bready", m_axi_bready, 1);
    aw_lat_cfg = 0;
    wait_idle();

    // Error counting and saturation.
    resp_cfg = 2'b10;
    for (int i = 0; i < 3; i++) send(1, 16'(i), 32'(i), rdy);
    wait_idle();
    resp_cfg = 2'b00;
    send(2, 16'h0020, 32'h0, rdy);
    wait_idle();
    check("err_three", err_count, 16'd3);
    @(posedge aclk); #1;
    force dut.err_cnt_q = 16'hFFFC;
    preload_req = 1'b1;
    @(negedge aclk);
    @(posedge aclk); #1;
    release dut.err_cnt_q;
    preload_req = 1'b0;
    resp_cfg = 2'b10;
    for (int i = 0; i < 5; i++) send(3, 16'(i), 32'(i), rdy);
    wait_idle();
    check("err_saturate", err_count, 16'hFFFF);
    resp_cfg = 2'b00;

    // Reset while the address phase is stalled.
    aw_lat_cfg = 5;
    send(2, 16'h0202, 32'h02020202, rdy);
    #2;
    check("pre_rst_awvalid", m_axi_awvalid, 1);
    areset = 1'b1;
    #1;
    check("midrst_awvalid", m_axi_awvalid, 0);
    check("midrst_wvalid", m_axi_wvalid, 0);
    check("midrst_bready", m_axi_bready, 0);
    check("midrst_busy", busy, 0);
    check("midrst_grant", grant, 2'd3);
    aw_lat_cfg = 0;
    repeat (2) @(negedge aclk);
    @(posedge aclk); #1;
    areset = 1'b0;
    s_axis_tvalid = 4'b0101;
    s_axis_tdata[0 +: CW] = {16'h0A0A, 32'hA0A0A0A0};
    s_axis_tdata[2*CW +: CW] = {16'h0C0C, 32'hC0C0C0C0};
    @(negedge aclk);
    check("postrst_tready", s_axis_tready, 4'b0001);
    @(posedge aclk); #1;
    s_axis_tvalid = '0;
    wait_idle();

    // Random traffic on both sides, checked by the model every cycle.
    slv_rand = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge aclk);
      hs = s_axis_tready & s_axis_tvalid;
      @(posedge aclk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hs[p] || !s_axis_tvalid[p]) begin
          if ($urandom_range(0, 99) < 35) begin
            s_axis_tvalid[p] = 1'b1;
            s_axis_tdata[p*CW +: CW] = {16'($urandom), 32'($urandom)};
          end else begin
            s_axis_tvalid[p] = 1'b0;
          end
        end else if ($urandom_range(0, 99) < 5) begin
          s_axis_tvalid[p] = 1'b0;
        end
      end
    end
    @(posedge aclk); #1;
    s_axis_tvalid = '0;
    wait_idle();
    slv_rand = 1'b0;
    repeat (2) @(negedge aclk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
